// File: rtl/aes_pkg.sv
// Shared AES types, S-box and GF(2^8) helpers for the streaming core.
// Round transforms are functions so the datapath reads as the cipher does.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;
  typedef byte_t [0:3][0:3] state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT
  } fsm_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nr_of(int kb);
    return (kb == 256) ? 14 : 10;
  endfunction

  function automatic byte_t sbox(byte_t b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t rcon(logic [3:0] i);
    byte_t r;
    r = 8'h01;
    for (int k = 1; k < 15; k++)
      if (k < int'(i)) r = xtime(r);
    return r;
  endfunction

  function automatic word_t sub_word(word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic state_t sub_bytes(state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = sbox(s[c][r]);
    return o;
  endfunction

  function automatic state_t shift_rows(state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = s[(c + r) % 4][r];
    return o;
  endfunction

  function automatic state_t mix_cols(state_t s);
    state_t o;
    byte_t a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[c][0];
      a1 = s[c][1];
      a2 = s[c][2];
      a3 = s[c][3];
      o[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_stream_core_if.sv
// Plaintext/key in and ciphertext out valid/ready bundle.
// The core takes the slave side.
interface aes_stream_core_if #(
  parameter int KEY_BITS = 128
) ();
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_data;
  logic [KEY_BITS-1:0] in_key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_key_step.sv
// One round of on-the-fly key expansion for a 4- or 8-word window.
// rkey is the key to mix into the current round.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] win,
  input  logic [3:0]          round,
  input  logic                rot,
  output logic [KEY_BITS-1:0] nxt,
  output logic [127:0]        rkey
);
  word_t last, t, n0, n1, n2, n3;
  logic [3:0] ri;

  assign last = win[31:0];

  // 256-bit keys use one Rcon per pair of rounds
  assign ri = (KEY_BITS == 128) ? round
            : 4'(({1'b0, round} + 5'd1) >> 1);

  always_comb begin
    t = rot ? sub_word({last[23:0], last[31:24]}) ^ {rcon(ri), 24'h0}
            : sub_word(last);
    n0 = win[KEY_BITS-1 -: 32] ^ t;
    n1 = win[KEY_BITS-33 -: 32] ^ n0;
    n2 = win[KEY_BITS-65 -: 32] ^ n1;
    n3 = win[KEY_BITS-97 -: 32] ^ n2;
  end

  generate
    if (KEY_BITS == 128) begin : g_k128
      assign nxt  = {n0, n1, n2, n3};
      assign rkey = {n0, n1, n2, n3};
    end else begin : g_k256
      assign nxt  = {win[127:0], n0, n1, n2, n3};
      assign rkey = win[127:0];
    end
  endgenerate
endmodule

// File: rtl/aes_stream_core.sv
// Iterative AES-128/256 encryptor, one round per cycle,
// with a one-entry output buffer behind a valid/ready handshake.
module aes_stream_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic           clk,
  input  logic           rst,
  aes_stream_core_if.slave bus,
  output logic           busy
);
  localparam int NR = nr_of(KEY_BITS);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad
      $error("aes_stream_core: KEY_BITS must be 128 or 256");
    end
  endgenerate

  fsm_t                fsm;
  logic [3:0]          round;
  state_t              st;
  logic [KEY_BITS-1:0] win;
  logic [KEY_BITS-1:0] nxt;
  logic [127:0]        rkey;
  logic [127:0]        rnd_out;
  logic [127:0]        obuf;
  logic                ovalid;
  logic                rdy;
  logic                rot;
  logic                last_rnd;
  logic                free;

  assign rot      = (KEY_BITS == 128) || round[0];
  assign last_rnd = (round == 4'(NR));
  assign free     = !ovalid || bus.out_ready;

  aes_key_step #(
    .KEY_BITS(KEY_BITS)
  ) u_key (
    .win  (win),
    .round(round),
    .rot  (rot),
    .nxt  (nxt),
    .rkey (rkey)
  );

  always_comb begin
    state_t sr;
    sr = shift_rows(sub_bytes(st));
    rnd_out = (last_rnd ? sr : mix_cols(sr)) ^ rkey;
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ovalid;
  assign bus.out_data  = obuf;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= IDLE;
      round  <= '0;
      st     <= '0;
      win    <= '0;
      obuf   <= '0;
      ovalid <= 1'b0;
      rdy    <= 1'b1;
      busy   <= 1'b0;
    end else begin
      if (ovalid && bus.out_ready) ovalid <= 1'b0;
      unique case (fsm)
        IDLE: if (bus.in_valid) begin
          st    <= bus.in_data ^ bus.in_key[KEY_BITS-1 -: 128];
          win   <= bus.in_key;
          round <= 4'd1;
          fsm   <= RUN;
          rdy   <= 1'b0;
          busy  <= 1'b1;
        end
        RUN: begin
          st    <= rnd_out;
          win   <= nxt;
          round <= round + 4'd1;
          if (last_rnd) begin
            if (free) begin
              obuf   <= rnd_out;
              ovalid <= 1'b1;
              fsm    <= IDLE;
              rdy    <= 1'b1;
              busy   <= 1'b0;
            end else begin
              fsm <= WAIT;
            end
          end
        end
        WAIT: if (free) begin
          obuf   <= st;
          ovalid <= 1'b1;
          fsm    <= IDLE;
          rdy    <= 1'b1;
          busy   <= 1'b0;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_stream_core.sv
// Bench for aes_stream_core: known vectors, corner sequences and
// random streaming against a from-scratch FIPS-197 model.
module tb_aes_stream_core;
  logic clk, rst, busy128, busy256;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb [256];

  aes_stream_core_if #(.KEY_BITS(128)) i128 ();
  aes_stream_core_if #(.KEY_BITS(256)) i256 ();

  aes_stream_core #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .bus(i128.slave), .busy(busy128));
  aes_stream_core #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .bus(i256.slave), .busy(busy256));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(logic [127:0] pt,
                                           logic [255:0] key, bit k);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [127:0] o;
    nk = k ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[8*(15-i) +: 8] ^ w[i/4][8*(3-i%4) +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int i = 0; i < 16; i++)
        u[i] = s[4*((i/4 + i%4) % 4) + i%4];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          if (r < nr)
            s[4*c+j] = gmul(8'h02, u[4*c+j]) ^ gmul(8'h03, u[4*c+(j+1)%4])
                     ^ u[4*c+(j+2)%4] ^ u[4*c+(j+3)%4];
          else
            s[4*c+j] = u[4*c+j];
      for (int i = 0; i < 16; i++)
        s[i] ^= w[4*r + i/4][8*(3-i%4) +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = s[i];
    return o;
  endfunction

  function automatic logic ov(bit k);
    return k ? i256.out_valid : i128.out_valid;
  endfunction
  function automatic logic [127:0] od(bit k);
    return k ? i256.out_data : i128.out_data;
  endfunction
  function automatic logic ir(bit k);
    return k ? i256.in_ready : i128.in_ready;
  endfunction
  function automatic logic bs(bit k);
    return k ? busy256 : busy128;
  endfunction

  function automatic logic [255:0] r256();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit k, logic v, logic [127:0] d, logic [255:0] key);
    if (k) begin
      i256.in_valid = v;
      i256.in_data  = d;
      i256.in_key   = key;
    end else begin
      i128.in_valid = v;
      i128.in_data  = d;
      i128.in_key   = key[127:0];
    end
  endtask

  task automatic set_ordy(bit k, logic v);
    if (k) i256.out_ready = v;
    else   i128.out_ready = v;
  endtask

  task automatic run_block(bit k, logic [127:0] pt, logic [255:0] key,
                           output logic [127:0] ct, output int lat);
    drive(k, 1, pt, key);
    tick();
    lat = 1;
    while (!ov(k) && lat < 40) begin
      drive(k, 0, r256()[127:0], r256());
      tick();
      lat++;
    end
    ct = od(k);
    drive(k, 0, '0, '0);
    tick();
  endtask

  task automatic stream(bit k, int nblk);
    logic [127:0] q [$];
    logic [127:0] pt;
    logic [255:0] key;
    logic v, rd;
    int sent, got, cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < nblk && cyc < 4000) begin
      rd = ($urandom_range(0, 2) != 0);
      v = (sent < nblk) && ($urandom_range(0, 1) != 0);
      pt = r256()[127:0];
      key = r256();
      set_ordy(k, rd);
      drive(k, v, pt, key);
      if (v && ir(k)) begin
        q.push_back(aes_ref(pt, key, k));
        sent++;
      end
      if (ov(k) && rd) begin
        chk($sformatf("stream%0d blk%0d", k ? 256 : 128, got),
            od(k), (q.size() > 0) ? q.pop_front() : 128'hx);
        got++;
      end
      tick();
      cyc++;
    end
    if (got < nblk) chk("stream timeout", 128'(got), 128'(nblk));
    drive(k, 0, '0, '0);
    set_ordy(k, 1);
    tick();
    tick();
  endtask

  typedef struct {
    bit           k;
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] ct;
  } vec_t;

  initial begin
    vec_t tv [3];
    logic [127:0] ct, ca, cb, pa, pb;
    logic [255:0] ka, kb;
    logic [7:0] inv, b, s;
    int lat, n;

    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s = b ^ 8'h63;
      for (int j = 1; j < 5; j++) begin
        b = {b[6:0], b[7]};
        s ^= b;
      end
      sb[x] = s;
    end

    tv[0] = '{0, 128'h00112233445566778899aabbccddeeff,
              256'h000102030405060708090a0b0c0d0e0f,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tv[1] = '{0, 128'h3243f6a8885a308d313198a2e0370734,
              256'h2b7e151628aed2a6abf7158809cf4f3c,
              128'h3925841d02dc09fbdc118597196a0b32};
    tv[2] = '{1, 128'h00112233445566778899aabbccddeeff,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h8ea2b7ca516745bfeafc49904b496089};

    rst = 1;
    drive(0, 0, '0, '0);
    drive(1, 0, '0, '0);
    set_ordy(0, 1);
    set_ordy(1, 1);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst in_ready %0d", k), 128'(ir(k)), 128'd1);
      chk($sformatf("rst out_valid %0d", k), 128'(ov(k)), 128'd0);
      chk($sformatf("rst out_data %0d", k), od(k), 128'd0);
      chk($sformatf("rst busy %0d", k), 128'(bs(k)), 128'd0);
    end
    rst = 0;
    tick();

    for (int i = 0; i < 3; i++) begin
      run_block(tv[i].k, tv[i].pt, tv[i].key, ct, lat);
      chk($sformatf("vec%0d ct", i), ct, tv[i].ct);
      chk($sformatf("vec%0d latency", i), 128'(lat),
          128'(tv[i].k ? 15 : 11));
      chk($sformatf("vec%0d drained", i), 128'(ov(tv[i].k)), 128'd0);
    end

    pa = r256()[127:0];
    pb = r256()[127:0];
    ka = r256();
    kb = r256();
    ca = aes_ref(pa, ka, 0);
    cb = aes_ref(pb, kb, 0);
    set_ordy(0, 0);
    drive(0, 1, pa, ka);
    tick();
    drive(0, 0, '0, '0);
    n = 0;
    while (!ir(0) && n < 40) begin
      tick();
      n++;
    end
    drive(0, 1, pb, kb);
    tick();
    drive(0, 0, r256()[127:0], r256());
    chk("bp first valid", 128'(ov(0)), 128'd1);
    chk("bp first data", od(0), ca);
    repeat (13) begin
      drive(0, 0, r256()[127:0], r256());
      tick();
    end
    chk("bp wait busy", 128'(bs(0)), 128'd1);
    chk("bp wait in_ready", 128'(ir(0)), 128'd0);
    chk("bp held data", od(0), ca);
    set_ordy(0, 1);
    tick();
    chk("bp second valid", 128'(ov(0)), 128'd1);
    chk("bp second data", od(0), cb);
    chk("bp idle in_ready", 128'(ir(0)), 128'd1);
    chk("bp idle busy", 128'(bs(0)), 128'd0);
    tick();
    chk("bp drained", 128'(ov(0)), 128'd0);

    drive(0, 1, pa, ka);
    tick();
    drive(0, 0, '0, '0);
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid rst in_ready", 128'(ir(0)), 128'd1);
    chk("mid rst out_valid", 128'(ov(0)), 128'd0);
    chk("mid rst out_data", od(0), 128'd0);
    chk("mid rst busy", 128'(bs(0)), 128'd0);
    repeat (12) tick();
    chk("mid rst no output", 128'(ov(0)), 128'd0);
    run_block(0, tv[1].pt, tv[1].key, ct, lat);
    chk("after rst ct", ct, tv[1].ct);

    stream(0, 12);
    stream(1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_stream_core.md
Name: aes_stream_core

Overview:
Iterative AES encryption core, parametrised for 128- or 256-bit keys. It computes one round per cycle with on-the-fly key expansion. Valid/ready handshakes on input and output, plus a one-entry output buffer, let a new block start while the previous ciphertext waits for the consumer. It is the streaming successor of the fixed AES-128 encryptor and the encryption engine for the datapath's upcoming mode wrappers.

Parameters:
KEY_BITS, 128, key length; legal values 128 or 256, anything else is an elaboration error
NR, derived (10 or 14), round count; not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext/key pair offered
in_ready  output  1  core can accept a block this cycle
in_data  input  128  plaintext, byte 0 = bits 127:120, column-major state order
in_key  input  KEY_BITS  cipher key, byte 0 = MSB byte
out_valid  output  1  ciphertext held in output buffer
out_ready  input  1  consumer accepts ciphertext
out_data  output  128  ciphertext, same byte order as in_data
busy  output  1  round engine active (RUN or WAIT)

Behaviour:
- Reset (rst=1 at an edge): FSM to IDLE; round counter 0; state, key window and output buffer cleared to 0. After the edge: in_ready=1, out_valid=0, out_data=0, busy=0. Reset mid-operation abandons the block; no partial output appears.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, load state = in_data ^ in_key[KEY_BITS-1 -: 128], load the key window with in_key, set round=1, go to RUN.
  - RUN: each cycle apply SubBytes, ShiftRows, MixColumns (MixColumns omitted when round==NR), then AddRoundKey with the round-r key. Advance the key window and increment round. When round==NR and the output buffer is empty or draining this cycle (out_ready=1), write the buffer and go to IDLE. Otherwise go to WAIT with the final result held in the state register.
  - WAIT: in_ready=0. Transfer the state to the buffer on the first cycle the buffer is empty or draining, then go to IDLE.
- Latency: acceptance at edge T gives out_valid=1 after edge T+NR (11 edges for KEY_BITS=128, 15 for KEY_BITS=256), provided the buffer is free.
- Throughput: one block per NR+1 cycles; in_ready is low in RUN and WAIT.
- Output buffer: out_valid stays set and out_data stays stable until out_valid&&out_ready. If a buffer write and a drain occur in the same cycle, the write wins: out_valid stays 1 and the new data appears.
- in_data/in_key are sampled only at the acceptance edge; later changes are ignored.
- Key expansion, KEY_BITS=128: FIPS-197 schedule, one 4-word step per round, Rcon indexed by round.
- Key expansion, KEY_BITS=256:
  - 8-word window; each round shifts in 4 new words.
  - The step alternates between RotWord+SubWord+Rcon (round-key index multiple of 8 words) and SubWord only (index ≡ 4 mod 8).
  - Round 1 uses in_key[127:0] directly.
  - Rcon advances only on RotWord steps.
- Rcon: GF(2^8) doubling, x^8+x^4+x^3+x+1; 0x80 wraps to 0x1b.
- No decryption, no back-pressure on in_key independent of in_data; the key is re-expanded for every block.

Decomposition:
- Package aes_pkg holds:
  - state typedef: 4x4 byte array, column-major
  - byte/word typedefs
  - S-box constant table
  - xtime function
  - Rcon function
  - nr_of(KEY_BITS) function
  - FSM enum {IDLE, RUN, WAIT}
- Round datapath reuses the existing SubBytes, ShiftRows, MixCols and AddRoundKey blocks.
- One new sub-module, aes_key_step: combinational next-window generator, parametrised by KEY_BITS, with inputs window, round and step-type.

Test Plan:
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rises exactly 11 edges after acceptance.
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32.
- KEY_BITS=256, key 000102…1e1f, pt 00112233445566778899aabbccddeeff → 8ea2b7ca516745bfeafc49904b496089, latency 15 edges.
- Back-pressure: out_ready=0, two blocks issued back-to-back:
  - first result is held stable;
  - second block runs, enters WAIT, busy=1, in_ready=0;
  - raising out_ready gives both ciphertexts in order with no loss or duplication.
- Assert rst for 1 cycle at round 5 → next cycle in_ready=1, out_valid=0, out_data=0; a fresh block then yields the correct ciphertext.
- Change in_data/in_key every cycle during RUN → ciphertext matches the values sampled at acceptance only.
